// File: rtl/pwr_core_iso_sequencer.sv
// pwr_core_iso_sequencer
// Core-domain boundary register plus the power-down / power-up sequencer for
// the DSP domain: isolate, save retention, switch off, and the reverse on wake.
// Boundary data is clamped to CLAMP_VAL whenever isolation is enabled.
// Optional feature macro: PWR_SEQ_TIMEOUT_EN (bounded switch-ack waits with a
// sticky FAULT state and err_timeout flag).
module pwr_core_iso_sequencer #(
  parameter int              DW          = 32,
  parameter logic [DW-1:0]   CLAMP_VAL   = '0,
  parameter int              ISO_SETTLE  = 2,
  parameter int              ACK_TIMEOUT = 64
) (
  input  logic          clk_core,
  input  logic          rst_n,
  input  logic [DW-1:0] data_in,
  input  logic          data_in_valid,
  output logic [DW-1:0] data_out,
  output logic          data_out_valid,
  input  logic          pd_req,
  input  logic          pu_req,
  output logic          pwr_sw_off_req,
  input  logic          pwr_sw_off_ack,
  output logic          iso_en,
  output logic          ret_save,
  output logic          ret_restore,
  output logic          seq_busy,
  output logic          seq_done,
  output logic          err_timeout
);

  localparam int            CW          = (ISO_SETTLE > 1) ? $clog2(ISO_SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(ISO_SETTLE - 1);

  typedef enum logic [3:0] {
    ST_ON,
    ST_ISO,
    ST_SAVE,
    ST_OFF_REQ,
    ST_OFF,
    ST_ON_REQ,
    ST_RESTORE,
    ST_UNISO
`ifdef PWR_SEQ_TIMEOUT_EN
    , ST_FAULT
`endif
  } state_t;

  state_t          state;
  logic [CW-1:0]   settle_cnt;
  logic            ack_m;
  logic            ack_s;
  logic [DW-1:0]   data_q;
  logic            valid_q;

`ifdef PWR_SEQ_TIMEOUT_EN
  localparam int            TW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
  logic [TW-1:0]   to_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous power-switch acknowledge.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= pwr_sw_off_ack;
      ack_s <= ack_m;
    end
  end

  // Boundary data register; only loads while the domain is fully on.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (state == ST_ON) begin
      valid_q <= data_in_valid;
      if (data_in_valid) data_q <= data_in;
    end else begin
      valid_q <= 1'b0;
    end
  end

  // Isolation clamp overrides the register as soon as iso_en is high.
  assign data_out       = iso_en ? CLAMP_VAL : data_q;
  assign data_out_valid = valid_q & ~iso_en;

  // Power sequencing FSM with registered control outputs.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_ON;
      settle_cnt     <= '0;
      iso_en         <= 1'b0;
      pwr_sw_off_req <= 1'b0;
      ret_save       <= 1'b0;
      ret_restore    <= 1'b0;
      seq_busy       <= 1'b0;
      seq_done       <= 1'b0;
`ifdef PWR_SEQ_TIMEOUT_EN
      to_cnt         <= '0;
      err_timeout    <= 1'b0;
`endif
    end else begin
      ret_save    <= 1'b0;
      ret_restore <= 1'b0;
      seq_done    <= 1'b0;
      case (state)
        ST_ON: begin
          if (pd_req) begin
            state      <= ST_ISO;
            iso_en     <= 1'b1;
            seq_busy   <= 1'b1;
            settle_cnt <= '0;
          end
        end
        ST_ISO: begin
          if (settle_cnt == SETTLE_LAST) begin
            state    <= ST_SAVE;
            ret_save <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_SAVE: begin
          state          <= ST_OFF_REQ;
          pwr_sw_off_req <= 1'b1;
`ifdef PWR_SEQ_TIMEOUT_EN
          to_cnt         <= '0;
`endif
        end
        ST_OFF_REQ: begin
          if (ack_s) begin
            state    <= ST_OFF;
            seq_done <= 1'b1;
            seq_busy <= 1'b0;
          end
`ifdef PWR_SEQ_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state       <= ST_FAULT;
            err_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ST_OFF: begin
          if (pu_req) begin
            state          <= ST_ON_REQ;
            pwr_sw_off_req <= 1'b0;
            seq_busy       <= 1'b1;
`ifdef PWR_SEQ_TIMEOUT_EN
            to_cnt         <= '0;
`endif
          end
        end
        ST_ON_REQ: begin
          if (!ack_s) begin
            state       <= ST_RESTORE;
            ret_restore <= 1'b1;
          end
`ifdef PWR_SEQ_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state       <= ST_FAULT;
            err_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ST_RESTORE: begin
          state      <= ST_UNISO;
          settle_cnt <= '0;
        end
        ST_UNISO: begin
          if (settle_cnt == SETTLE_LAST) begin
            state    <= ST_ON;
            iso_en   <= 1'b0;
            seq_done <= 1'b1;
            seq_busy <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
`ifdef PWR_SEQ_TIMEOUT_EN
        ST_FAULT: begin
          // Terminal until reset: stay isolated, keep the switch request as is.
          state <= ST_FAULT;
        end
`endif
        default: begin
          state <= ST_ON;
        end
      endcase
    end
  end

endmodule

// File: doc/pwr_core_iso_sequencer.md
Name: pwr_core_iso_sequencer

Overview:
- Core-domain boundary stage that registers core data and drives it across to the DSP power domain.
- Sequences the DSP-domain power-down and power-up: clamp outputs, save retention, request switch off, then the reverse order on wake.
- Clamps the boundary data to a fixed value whenever isolation is active.
- Runs entirely on clk_core; the power-switch acknowledge is asynchronous and synchronised internally.

Parameters:
- DW, 32, data path width.
- CLAMP_VAL, 0, value driven on data_out while isolated (DW bits).
- ISO_SETTLE, 2, cycles held in ISO and UNISO before advancing; must be >=1.
- ACK_TIMEOUT, 64, max cycles waiting for switch ack (only with the optional feature).

Ports:
- clk_core  in  1  core clock.
- rst_n  in  1  asynchronous reset, active-low.
- data_in  in  DW  core data.
- data_in_valid  in  1  qualifies data_in.
- data_out  out  DW  boundary data to the DSP domain.
- data_out_valid  out  1  qualifies data_out.
- pd_req  in  1  power-down request, level-sampled.
- pu_req  in  1  power-up request, level-sampled.
- pwr_sw_off_req  out  1  switch-off request to the power switch.
- pwr_sw_off_ack  in  1  async; 1 = domain fully off, 0 = fully on.
- iso_en  out  1  isolation enable.
- ret_save  out  1  one-cycle retention save pulse.
- ret_restore  out  1  one-cycle retention restore pulse.
- seq_busy  out  1  high in any state other than ON or OFF.
- seq_done  out  1  one-cycle pulse on entry to ON or OFF from a transition state.
- err_timeout  out  1  sticky timeout flag (optional feature only).

Behaviour:
- Reset values: state ON, data_out=0, data_out_valid=0, iso_en=0, pwr_sw_off_req=0, ret_save=0, ret_restore=0, seq_busy=0, seq_done=0, err_timeout=0, settle counter 0, ack synchroniser flops 0.
- Ack synchroniser: pwr_sw_off_ack passes through a 2-flop synchroniser; ack_s is valid 2 cycles after the input changes.
- Data path, ON state:
  - data_out <= data_in and data_out_valid <= data_in_valid; 1-cycle latency.
  - When data_in_valid=0, data_out holds its value and data_out_valid=0.
- Data path, all other states: data_out=CLAMP_VAL and data_out_valid=0, combinationally from iso_en.
- FSM, states ON, ISO, SAVE, OFF_REQ, OFF, ON_REQ, RESTORE, UNISO:
  - ON: pd_req=1 -> ISO; iso_en rises the same edge; pu_req ignored.
  - ISO: counter counts ISO_SETTLE cycles -> SAVE.
  - SAVE: ret_save=1 for exactly 1 cycle -> OFF_REQ.
  - OFF_REQ: pwr_sw_off_req=1; wait ack_s=1 -> OFF; seq_done pulses.
  - OFF: iso_en=1, pwr_sw_off_req=1; pu_req=1 -> ON_REQ; pd_req ignored.
  - ON_REQ: pwr_sw_off_req=0; wait ack_s=0 -> RESTORE.
  - RESTORE: ret_restore=1 for 1 cycle -> UNISO.
  - UNISO: iso_en stays 1 for ISO_SETTLE cycles -> ON; iso_en=0 and seq_done pulses.
- Requests arriving in transition states are ignored, not queued. pd_req and pu_req both high in ON: pd_req wins.
- Settle counter is reset to 0 on every entry to ISO and UNISO.
- Minimum ON->OFF time: ISO_SETTLE+1+3 cycles, given ack asserted at the first off_req cycle.
- Reset mid-sequence: everything returns immediately to reset values, including iso_en=0 and off_req=0. System reset must cover domain power-on.

Optional Feature:
- Macro PWR_SEQ_TIMEOUT_EN defined:
  - A counter runs in OFF_REQ and ON_REQ and clears on state entry.
  - Reaching ACK_TIMEOUT cycles without the expected ack_s value enters state FAULT and sets err_timeout=1 (sticky).
  - FAULT holds iso_en=1 and the current pwr_sw_off_req value, keeps seq_busy=1, ignores all requests, and is left only by reset.
- Macro not defined: no counter, no FAULT state, err_timeout tied to 0, and waits are unbounded.

Test Plan:
- Reset, then data_in=32'hDEADBEEF with valid=1 for 1 cycle -> next cycle data_out=32'hDEADBEEF and data_out_valid=1; the following cycle valid=0 and data holds.
- pd_req pulse in ON, ack raised 1 cycle after off_req -> iso_en=1 same edge; ret_save at cycle 3; off_req from cycle 4; seq_done once ack_s=1; data_out=0 and valid=0 throughout.
- From OFF, pu_req, ack dropped 5 cycles later -> off_req=0 immediately; ret_restore 1 cycle after ack_s=0; iso_en falls ISO_SETTLE=2 cycles later; seq_done pulses; data passes again.
- pd_req and pu_req high together in ON -> power-down sequence runs; pu_req held during ISO/SAVE has no effect.
- rst_n asserted in OFF_REQ -> same cycle (async) iso_en=0, off_req=0, state ON, data_out=0.
- With PWR_SEQ_TIMEOUT_EN and ACK_TIMEOUT=64, ack never asserted -> after 64 cycles in OFF_REQ err_timeout=1, iso_en=1, off_req=1, pu_req/pd_req ignored until reset.
